dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache with its controller FSM, placed in the memory stage between the pipeline and a single-port backing memory.
- Drives the pipeline-wide cache_stall consumed by the hazard unit.
- A load/store hit completes in the same cycle with no stall.
- A miss freezes the pipeline while the FSM writes back the victim line (if dirty) and refills the line over a one-word-per-beat ready/valid memory port.

Parameters:
- DATA_WIDTH, 32, word width; also the address width.
- SETS, 64, number of lines; power of two.
- WORDS_PER_LINE, 4, words per line; power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_re  input  1  load request from the M stage.
- cpu_we  input  1  store request from the M stage; has priority if both cpu_re and cpu_we are high.
- cpu_addr  input  DATA_WIDTH  byte address. Fields: offset [3:0], index [9:4], tag [31:10] at default parameters.
- cpu_wdata  input  DATA_WIDTH  store data, already lane-aligned.
- cpu_byte_en  input  4  store byte lanes.
- cpu_rdata  output  DATA_WIDTH  load word; combinational; 0 when not a hit.
- cache_stall  output  1  freeze pipeline; combinational.
- mem_req  output  1  beat request to backing memory.
- mem_we  output  1  1 = write beat, 0 = read beat.
- mem_addr  output  DATA_WIDTH  word-aligned beat address.
- mem_wdata  output  DATA_WIDTH  write beat data.
- mem_rdata  input  DATA_WIDTH  read beat data; valid when mem_ready is high.
- mem_ready  input  1  beat completes on a cycle with mem_req & mem_ready.
- hit_count  output  32  number of hits; wraps.
- miss_count  output  32  number of misses; wraps.

Behaviour:
- Reset (asynchronous):
  - All valid and dirty bits cleared; FSM to IDLE; beat counter to 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
  - Data and tag arrays are not reset.
  - Reset mid-transfer abandons the transfer immediately; memory-side partial writes are acceptable.
- Lookup (IDLE): hit = valid[index] & (tag[index]==cpu_addr tag) & (cpu_re|cpu_we).
- Load hit: cpu_rdata = line word selected by cpu_addr[3:2]; cache_stall=0; hit_count+1 at the edge.
- Store hit: selected bytes written at the edge per cpu_byte_en; dirty[index]=1; cache_stall=0; hit_count+1.
- Miss in IDLE: cache_stall=1 in the same cycle; miss_count+1 at the edge. Next state is WRITEBACK if the victim is valid & dirty, else REFILL. The latched victim tag is used for writeback addresses.
- cache_stall equals (request & ~hit) in IDLE, and 1 in WRITEBACK, REFILL and UPDATE.
- The pipeline holds cpu_* stable while stalled; the controller does not latch the request.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim_tag, index, beat, 2'b00}; mem_wdata = line word[beat].
  - beat advances only on mem_ready; outputs stay stable while mem_ready is low.
  - After beat WORDS_PER_LINE-1 completes: beat=0, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0; mem_addr = {cpu tag, index, beat, 2'b00}.
  - On mem_ready, mem_rdata is written into word[beat].
  - After the last beat: go to UPDATE.
- UPDATE (1 cycle): mem_req=0; tag written; valid=1; dirty=0. Next state is IDLE.
- Replay: in IDLE the held request re-looks-up and hits. Stall drops that cycle, and hit_count also increments. Miss latency is 2 + beats, plus ready wait cycles.
- mem_ready while mem_req=0 is ignored.
- Store miss allocates first, then the replayed store hits and sets dirty.
- Counters wrap 0xFFFF_FFFF -> 0.

Decomposition:
- cache_pkg holds:
  - state enum {IDLE, WRITEBACK, REFILL, UPDATE};
  - localparams OFFSET_W, INDEX_W, TAG_W and BEAT_W, derived from SETS and WORDS_PER_LINE;
  - field-extract helper functions.
- One sub-module, dcache_line_store:
  - tag, valid, dirty and data arrays;
  - combinational read port;
  - one byte-enabled word write port;
  - tag/valid/dirty update port.
- The FSM, beat counter and counters stay in dcache_controller.

Test Plan:
- Cold load miss:
  - Stimulus: after reset, load 0x0000_0100; memory returns 0xA0, 0xA1, 0xA2, 0xA3.
  - Required: stall=1; read beats to 0x100, 0x104, 0x108, 0x10C; then stall=0 with cpu_rdata=0xA0; miss_count=1, hit_count=1.
- Store hit:
  - Stimulus: store 0xDEADBEEF, byte_en 4'b1111 to 0x104, then load 0x104.
  - Required: no stall and no mem_req; load returns 0xDEADBEEF; hit_count=3.
- Byte store:
  - Stimulus: store with byte_en 4'b0010 and wdata 0x0000_5500 onto a word holding 0x1122_3344.
  - Required: load returns 0x1122_5544.
- Dirty conflict miss:
  - Stimulus: load 0x0000_0500 (same index 16).
  - Required: write beats to 0x100..0x10C with data 0xA0, 0xDEADBEEF, 0xA2, 0xA3; then read beats 0x500..0x50C; stall for 10 cycles at zero wait.
- Memory backpressure:
  - Stimulus: hold mem_ready=0 for 5 cycles on each beat.
  - Required: mem_addr, mem_wdata and mem_we stable; beat does not advance; stall stays 1.
- Reset mid-refill:
  - Stimulus: assert rst during beat 2 of a refill.
  - Required: mem_req=0 and stall=0 immediately, with no clock edge needed; the next load to the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
// Address layout (low to high): byte offset, word select, set index, tag.
package cache_pkg;

   localparam int unsigned DATA_WIDTH_DEF     = 32;
   localparam int unsigned SETS_DEF           = 64;
   localparam int unsigned WORDS_PER_LINE_DEF = 4;

   localparam int unsigned BEAT_W   = $clog2(WORDS_PER_LINE_DEF);
   localparam int unsigned OFFSET_W = BEAT_W + 2;
   localparam int unsigned INDEX_W  = $clog2(SETS_DEF);
   localparam int unsigned TAG_W    = DATA_WIDTH_DEF - INDEX_W - OFFSET_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

   function automatic int unsigned beat_bits(input int unsigned words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int unsigned index_bits(input int unsigned sets);
      return $clog2(sets);
   endfunction

   // Extract an address field of 'width' bits starting at bit 'lsb'.
   function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                              input int unsigned lsb,
                                              input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (addr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays for a direct-mapped cache: combinational read,
// one byte-enabled word write and a line fill (tag, valid, clear dirty) port.
module dcache_line_store
   import cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int unsigned SETS           = SETS_DEF,
   parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter int unsigned IDX_BITS       = index_bits(SETS),
   parameter int unsigned WORD_BITS      = beat_bits(WORDS_PER_LINE),
   parameter int unsigned TAG_BITS       = DATA_WIDTH - IDX_BITS - WORD_BITS - 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IDX_BITS-1:0]     index,
   input  logic [WORD_BITS-1:0]    rd_word,
   output logic [TAG_BITS-1:0]     rd_tag,
   output logic                    rd_valid,
   output logic                    rd_dirty,
   output logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    wr_en,
   input  logic [WORD_BITS-1:0]    wr_word,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    dirty_set,
   input  logic                    fill_en,
   input  logic [TAG_BITS-1:0]     fill_tag
);

   logic [TAG_BITS-1:0]   tag_mem  [SETS];
   logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS_PER_LINE];
   logic [SETS-1:0]       valid_q;
   logic [SETS-1:0]       dirty_q;

   assign rd_tag   = tag_mem[index];
   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_data  = data_mem[{index, rd_word}];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (dirty_set) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data contents are left unreset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[index] <= fill_tag;
      end
      if (wr_en) begin
         for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
            if (wr_be[b]) begin
               data_mem[{index, wr_word}][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller: same-cycle
// hits, stall on miss while the victim is written back and the line refilled.
module dcache_controller
   import cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int unsigned SETS           = SETS_DEF,
   parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_re,
   input  logic                    cpu_we,
   input  logic [DATA_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_byte_en,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    cache_stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ready,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
);

   localparam int unsigned BEAT_BITS = beat_bits(WORDS_PER_LINE);
   localparam int unsigned OFS_BITS  = BEAT_BITS + 2;
   localparam int unsigned IDX_BITS  = index_bits(SETS);
   localparam int unsigned TAG_BITS  = DATA_WIDTH - IDX_BITS - OFS_BITS;

   state_t                  state_q, state_d;
   logic [BEAT_BITS-1:0]    beat_q;
   logic [TAG_BITS-1:0]     victim_tag_q;

   logic [IDX_BITS-1:0]     cpu_index;
   logic [BEAT_BITS-1:0]    cpu_word;
   logic [TAG_BITS-1:0]     cpu_tag;
   logic                    req, lookup_hit, last_beat;

   logic [BEAT_BITS-1:0]    line_word, wr_word;
   logic [TAG_BITS-1:0]     rd_tag;
   logic                    rd_valid, rd_dirty;
   logic [DATA_WIDTH-1:0]   rd_data, wr_data;
   logic [DATA_WIDTH/8-1:0] wr_be;
   logic                    wr_en, dirty_set, fill_en;
   logic                    hit, miss, beat_adv, stall;

   assign cpu_index  = IDX_BITS'(addr_field(cpu_addr, OFS_BITS, IDX_BITS));
   assign cpu_word   = BEAT_BITS'(addr_field(cpu_addr, 2, BEAT_BITS));
   assign cpu_tag    = TAG_BITS'(addr_field(cpu_addr, OFS_BITS + IDX_BITS, TAG_BITS));
   assign req        = cpu_re | cpu_we;
   assign lookup_hit = rd_valid & (rd_tag == cpu_tag) & req;
   assign last_beat  = (beat_q == BEAT_BITS'(WORDS_PER_LINE - 1));

   dcache_line_store #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SETS           (SETS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IDX_BITS       (IDX_BITS),
      .WORD_BITS      (BEAT_BITS),
      .TAG_BITS       (TAG_BITS)
   ) u_line_store (
      .clk       (clk),
      .rst       (rst),
      .index     (cpu_index),
      .rd_word   (line_word),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_word   (wr_word),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .dirty_set (dirty_set),
      .fill_en   (fill_en),
      .fill_tag  (cpu_tag)
   );

   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      line_word = cpu_word;
      wr_en     = 1'b0;
      wr_word   = cpu_word;
      wr_data   = cpu_wdata;
      wr_be     = cpu_byte_en;
      dirty_set = 1'b0;
      fill_en   = 1'b0;
      hit       = 1'b0;
      miss      = 1'b0;
      beat_adv  = 1'b0;
      unique case (state_q)
         IDLE: begin
            hit   = lookup_hit;
            miss  = req & ~lookup_hit;
            stall = miss;
            if (lookup_hit && cpu_we) begin
               wr_en     = 1'b1;
               dirty_set = 1'b1;
            end
            if (miss) begin
               state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            line_word = beat_q;
            mem_addr  = {victim_tag_q, cpu_index, beat_q, 2'b00};
            mem_wdata = rd_data;
            if (mem_ready) begin
               beat_adv = 1'b1;
               if (last_beat) state_d = REFILL;
            end
         end
         REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {cpu_tag, cpu_index, beat_q, 2'b00};
            if (mem_ready) begin
               wr_en    = 1'b1;
               wr_word  = beat_q;
               wr_data  = mem_rdata;
               wr_be    = '1;
               beat_adv = 1'b1;
               if (last_beat) state_d = UPDATE;
            end
         end
         UPDATE: begin
            stall   = 1'b1;
            fill_en = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Gated by rst so the stall releases the instant reset is asserted, even
   // while the (now invalidated) request is still being held by the pipeline.
   assign cache_stall = stall & ~rst;
   assign cpu_rdata   = hit ? rd_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         victim_tag_q <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         state_q <= state_d;
         if (beat_adv) beat_q <= last_beat ? '0 : beat_q + 1'b1;
         if (miss) victim_tag_q <= rd_tag;
         if (hit) hit_count <= hit_count + 32'd1;
         if (miss) miss_count <= miss_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized self-checking bench for dcache_controller against a line-level
// cache model and a word-addressed backing memory model.
module tb_dcache_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_re = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [3:0]  cpu_byte_en = '0;
   logic [31:0] cpu_rdata;
   logic        cache_stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic [31:0] hit_count, miss_count;

   always #5 clk = ~clk;

   dcache_controller #(
      .DATA_WIDTH     (32),
      .SETS           (64),
      .WORDS_PER_LINE (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_re      (cpu_re),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_byte_en (cpu_byte_en),
      .cpu_rdata   (cpu_rdata),
      .cache_stall (cache_stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: backing memory plus per-set line state.
   logic [31:0] mem_model [logic [31:0]];
   bit          m_valid [64];
   bit          m_dirty [64];
   logic [21:0] m_tag   [64];
   logic [31:0] m_data  [64][4];
   int unsigned exp_hits = 0, exp_misses = 0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
      end
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   // One pipeline access, held until the stall drops. Called and returns at a negedge.
   task automatic access(input bit is_store, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int wait_lo, input int wait_hi,
                         output logic [31:0] rdata);
      int unsigned idx;
      int unsigned word;
      logic [21:0] tag;
      bit          is_hit;
      logic [31:0] q_addr[$];
      bit          q_we[$];
      logic [31:0] q_data[$];
      logic [31:0] fill[4];
      int          fill_n, stall_cycles, wait_cycles, wait_left, n_beats, cyc;
      logic [31:0] w;
      idx    = (addr >> 4) & 63;
      word   = (addr >> 2) & 3;
      tag    = addr[31:10];
      is_hit = m_valid[idx] && (m_tag[idx] == tag);
      fill_n = 0; stall_cycles = 0; wait_cycles = 0;
      if (!is_hit) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            for (int b = 0; b < 4; b++) begin
               q_addr.push_back({m_tag[idx], 10'd0} | (idx << 4) | (b << 2));
               q_we.push_back(1'b1);
               q_data.push_back(m_data[idx][b]);
            end
         end
         for (int b = 0; b < 4; b++) begin
            q_addr.push_back({tag, 10'd0} | (idx << 4) | (b << 2));
            q_we.push_back(1'b0);
            q_data.push_back(32'd0);
         end
      end
      n_beats = q_addr.size();
      cpu_re = !is_store; cpu_we = is_store;
      cpu_addr = addr; cpu_wdata = wdata; cpu_byte_en = be;
      wait_left = $urandom_range(wait_hi, wait_lo);
      for (cyc = 0; cyc < 400; cyc++) begin
         #1;
         if (!cache_stall) break;
         stall_cycles++;
         if (mem_req) begin
            if (q_addr.size() == 0) begin
               check_eq("extra_beat_req", {31'd0, mem_req}, 32'd0);
               mem_ready = 1'b1;
            end else begin
               check_eq("beat_addr", mem_addr, q_addr[0]);
               check_eq("beat_we", {31'd0, mem_we}, {31'd0, q_we[0]});
               if (q_we[0]) check_eq("beat_wdata", mem_wdata, q_data[0]);
               if (wait_left > 0) begin
                  mem_ready = 1'b0;
                  wait_left--;
                  wait_cycles++;
               end else begin
                  mem_ready = 1'b1;
                  if (q_we[0]) mem_model[q_addr[0]] = q_data[0];
                  else begin
                     mem_rdata = mem_read(q_addr[0]);
                     fill[fill_n] = mem_rdata;
                     fill_n++;
                  end
                  void'(q_addr.pop_front()); void'(q_we.pop_front()); void'(q_data.pop_front());
                  wait_left = $urandom_range(wait_hi, wait_lo);
               end
            end
         end else begin
            mem_ready = $urandom_range(1, 0);  // must be ignored without a request
            mem_rdata = $urandom;
         end
         @(negedge clk);
      end
      if (cyc == 400) check_eq("stall_timeout", {31'd0, cache_stall}, 32'd0);
      mem_ready = 1'b0;
      check_eq("beats_left", q_addr.size(), 32'd0);
      check_eq("stall_cycles", stall_cycles, is_hit ? 0 : n_beats + 2 + wait_cycles);
      check_eq("mem_req_on_hit", {31'd0, mem_req}, 32'd0);
      if (!is_hit) begin
         m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tag;
         for (int b = 0; b < 4; b++) m_data[idx][b] = fill[b];
         exp_misses++;
      end
      exp_hits++;
      rdata = cpu_rdata;
      if (is_store) begin
         w = m_data[idx][word];
         for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
         m_data[idx][word] = w;
         m_dirty[idx] = 1'b1;
      end else begin
         check_eq("load_rdata", cpu_rdata, m_data[idx][word]);
      end
      @(negedge clk);
      cpu_re = 1'b0; cpu_we = 1'b0;
      #1;
      check_eq("hit_count", hit_count, exp_hits);
      check_eq("miss_count", miss_count, exp_misses);
      @(negedge clk);
   endtask

   logic [31:0] rd;

   initial begin
      model_reset();
      for (int b = 0; b < 4; b++) mem_model[32'h100 + b*4] = 32'hA0 + b;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      check_eq("rst_hit_count", hit_count, 32'd0);
      check_eq("rst_miss_count", miss_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_eq("rst_stall", {31'd0, cache_stall}, 32'd0);
      @(negedge clk);

      // Cold miss, store hit, byte store.
      access(0, 32'h100, 0, 4'h0, 0, 0, rd);
      check_eq("cold_load", rd, 32'hA0);
      access(1, 32'h104, 32'hDEADBEEF, 4'hF, 0, 0, rd);
      access(0, 32'h104, 0, 4'h0, 0, 0, rd);
      check_eq("store_hit_load", rd, 32'hDEADBEEF);
      check_eq("store_hit_count", hit_count, 32'd3);
      access(0, 32'h200, 0, 4'h0, 0, 1, rd);
      access(1, 32'h204, 32'h1122_3344, 4'hF, 0, 0, rd);
      access(1, 32'h204, 32'h0000_5500, 4'b0010, 0, 0, rd);
      access(0, 32'h204, 0, 4'h0, 0, 0, rd);
      check_eq("byte_store", rd, 32'h1122_5544);

      // Dirty conflict miss at zero wait, then with 5 wait cycles on every beat.
      access(0, 32'h500, 0, 4'h0, 0, 0, rd);
      check_eq("conflict_load", rd, mem_read(32'h500));
      access(1, 32'h508, 32'hCAFE_F00D, 4'hF, 0, 0, rd);
      access(0, 32'h900, 0, 4'h0, 5, 5, rd);
      check_eq("wb_data_in_mem", mem_read(32'h508), 32'hCAFE_F00D);

      // Random traffic over a few tags and sets to force conflicts.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = ($urandom_range(3, 0) << 10) | ($urandom_range(7, 0) << 4) | ($urandom_range(3, 0) << 2);
         access($urandom_range(1, 0), a, $urandom, 4'($urandom), 0, 2, rd);
      end

      // Reset during beat 2 of a refill.
      begin
         int beats_done;
         bit hit_beat2;
         beats_done = 0; hit_beat2 = 1'b0;
         cpu_re = 1'b1; cpu_addr = 32'h7300;
         for (int c = 0; c < 50 && !hit_beat2; c++) begin
            #1;
            if (mem_req && !mem_we) begin
               if (beats_done == 2) begin
                  hit_beat2 = 1'b1;
                  mem_ready = 1'b0;
                  rst = 1'b1;
                  #1;
                  check_eq("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
                  check_eq("rst_mid_stall", {31'd0, cache_stall}, 32'd0);
               end else begin
                  mem_ready = 1'b1;
                  mem_rdata = mem_read(mem_addr);
                  beats_done++;
               end
            end else mem_ready = 1'b0;
            if (!hit_beat2) @(negedge clk);
         end
         check_eq("rst_mid_reached", {31'd0, hit_beat2}, 32'd1);
         @(negedge clk);
         @(negedge clk);
         rst = 1'b0; mem_ready = 1'b0; cpu_re = 1'b0;
         model_reset();
         #1 check_eq("rst_mid_counts", miss_count | hit_count, 32'd0);
         @(negedge clk);
         access(0, 32'h7300, 0, 4'h0, 0, 0, rd);
         check_eq("rst_remiss", miss_count, 32'd1);
      end

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = ($urandom_range(3, 0) << 10) | ($urandom_range(7, 0) << 4) | ($urandom_range(3, 0) << 2);
         access($urandom_range(1, 0), a, $urandom, 4'($urandom), 0, 3, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
